uart_tx_scheduler: RTL and testbench

- Round-robin scheduler that shares one UART transmitter among NUM_REQ byte requesters.
- Selects a requester and captures its byte, then issues a one-cycle start pulse to the TX datapath.
- Tracks the transmitter's busy handshake and enforces an inter-frame idle gap.
- Sits between on-chip byte sources (status, debug, echo) and the single 9600-baud TX serializer on the Basys 3 design.

---
 rtl/uart_tx_scheduler.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//
// Round-robin arbiter that shares a single UART TX serializer among NUM_REQ
// byte sources. It picks a requester, captures its byte, pulses tx_start for
// one cycle, then follows the serializer's tx_busy handshake. After each frame
// it enforces an idle gap before the next grant.
//
// Optional feature: define UART_TX_LOCK_EN to let the current owner keep the
// transmitter for up to MAX_BURST consecutive frames while req_lock is high.
// When the macro is undefined, req_lock is ignored and arbitration is pure
// round-robin.
//
// Ports:
//   clk_fpga     system clock (100 MHz)
//   reset_n      asynchronous active-low reset
//   req          per-requester request, held with stable data until ack
//   req_data     byte for requester i at [8i+7:8i]
//   req_lock     per-requester burst lock (UART_TX_LOCK_EN only)
//   ack          one-cycle pulse: byte captured and sent to TX
//   grant        one-hot current owner, 0 when idle
//   tx_data      byte to the serializer, held until the next capture
//   tx_start     one-cycle start pulse to the serializer
//   tx_busy      serializer busy, high for the duration of a frame
//   busy         high whenever the scheduler is not idle
//   timeout_err  sticky, set when tx_busy never rises after tx_start
//   err_clr      clears timeout_err (a simultaneous set wins)
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned GAP_CYCLES    = 0,
    parameter int unsigned START_TIMEOUT = 16,
    parameter int unsigned MAX_BURST     = 16
) (
    input  logic                 clk_fpga,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 busy,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    localparam int unsigned PtrW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TimerW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam int unsigned GapW   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitBusy,
        StWaitDone,
        StGap
    } state_e;

    state_e               state_q, state_d;
    logic [PtrW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [TimerW-1:0]    timer_q, timer_d;
    logic [GapW-1:0]      gap_q, gap_d;

    // Round-robin pick: first set request after the last owner, wrapping.
    logic                 sel_valid;
    logic [PtrW-1:0]      sel_idx;

    always_comb begin
        int unsigned cand;
        logic [PtrW-1:0] cand_idx;
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand     = (32'(ptr_q) + k) % NUM_REQ;
            cand_idx = PtrW'(cand);
            if (!sel_valid && req[cand_idx]) begin
                sel_valid = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

`ifdef UART_TX_LOCK_EN
    localparam int unsigned BurstW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    logic [BurstW-1:0] burst_q, burst_d;
    logic              relock;

    // The owner index is the pointer, which always holds the last grant.
    assign relock = req[ptr_q] && req_lock[ptr_q] && (burst_q < BurstW'(MAX_BURST - 1));

    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        err_d      = err_q;
`ifdef UART_TX_LOCK_EN
        burst_d    = burst_q;
`endif
        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (sel_valid) begin
                    state_d    = StStart;
                    grant_d    = NUM_REQ'(1) << sel_idx;
                    ack_d      = NUM_REQ'(1) << sel_idx;
                    tx_data_d  = req_data[{sel_idx, 3'b000} +: 8];
                    tx_start_d = 1'b1;
                    ptr_d      = sel_idx;
`ifdef UART_TX_LOCK_EN
                    burst_d    = '0;
`endif
                end
            end
            StStart: begin
                timer_d = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (timer_q == TimerW'(START_TIMEOUT - 1)) begin
                    // Frame is abandoned; the set overrides a same-cycle clear.
                    err_d   = 1'b1;
                    gap_d   = GapW'(GAP_CYCLES);
                    state_d = StGap;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    gap_d   = GapW'(GAP_CYCLES);
                    state_d = StGap;
                end
            end
            StGap: begin
                // Counter loaded with GAP_CYCLES, so GAP spans GAP_CYCLES+1 cycles.
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else begin
`ifdef UART_TX_LOCK_EN
                    if (relock) begin
                        state_d    = StStart;
                        ack_d      = NUM_REQ'(1) << ptr_q;
                        tx_data_d  = req_data[{ptr_q, 3'b000} +: 8];
                        tx_start_d = 1'b1;
                        burst_d    = burst_q + 1'b1;
                    end else begin
                        state_d = StIdle;
                        grant_d = '0;
                    end
`else
                    state_d = StIdle;
                    grant_d = '0;
`endif
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ptr_q      <= PtrW'(NUM_REQ - 1);
            grant_q    <= '0;
            ack_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            timer_q    <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
        end
    end

    assign grant       = grant_q;
    assign ack         = ack_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: NUM_REQ=4, GAP_CYCLES=5, START_TIMEOUT=16.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_tx_scheduler;

    localparam int unsigned NR  = 4;
    localparam int unsigned GAP = 5;
    localparam int unsigned TO  = 16;

    logic          clk_fpga = 1'b0;
    logic          reset_n  = 1'b0;
    logic [NR-1:0] req      = '0;
    logic [31:0]   req_data = '0;
    logic [NR-1:0] req_lock = '0;
    logic [NR-1:0] ack;
    logic [NR-1:0] grant;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy  = 1'b0;
    logic          busy;
    logic          timeout_err;
    logic          err_clr  = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk_fpga = ~clk_fpga;

    uart_tx_scheduler #(
        .NUM_REQ      (NR),
        .GAP_CYCLES   (GAP),
        .START_TIMEOUT(TO),
        .MAX_BURST    (3)
    ) dut (
        .clk_fpga   (clk_fpga),
        .reset_n    (reset_n),
        .req        (req),
        .req_data   (req_data),
        .req_lock   (req_lock),
        .ack        (ack),
        .grant      (grant),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .timeout_err(timeout_err),
        .err_clr    (err_clr)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int unsigned sel;
        logic [7:0]  exp;
        bit          hold;
        int unsigned blen;
    } frame_t;

    frame_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait (bounded) for the tx_start pulse; n = falling edges waited.
    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk_fpga);
            n++;
        end while (!tx_start && n < 40);
        check("start_seen", 32'(tx_start), 32'd1);
    endtask

    task automatic run_frame(input frame_t f);
        int n;
        logic [3:0] oh;
        oh       = 4'b0001 << f.sel;
        req      = f.req;
        req_data = f.data;
        wait_start(n);
        check("start_latency", n, 1);
        check("grant", 32'(grant), 32'(oh));
        check("ack", 32'(ack), 32'(oh));
        check("tx_data", 32'(tx_data), 32'(f.exp));
        check("busy_start", 32'(busy), 32'd1);
        if (!f.hold) req = '0;
        @(negedge clk_fpga);
        check("start_pulse_width", {28'(ack), 4'(tx_start)}, 32'd0);
        repeat (2) @(negedge clk_fpga);
        tx_busy = 1'b1;
        repeat (f.blen) @(negedge clk_fpga);
        check("held_during_frame", {ack, grant, tx_data, busy}, {oh ^ oh, oh, f.exp, 1'b1});
        tx_busy = 1'b0;
        repeat (GAP + 1) @(negedge clk_fpga);
        check("gap_last_cycle", {grant, busy}, {oh, 1'b1});
        @(negedge clk_fpga);
        check("idle_after_gap", {grant, busy}, 5'd0);
        check("no_timeout", 32'(timeout_err), 32'd0);
    endtask

    // tx_busy never rises; optionally hold err_clr across the setting edge.
    task automatic timeout_run(input bit clr_during);
        int n;
        req      = 4'b0001;
        req_data = 32'h0000_00EE;
        tx_busy  = 1'b0;
        err_clr  = clr_during;
        wait_start(n);
        check("to_tx_data", 32'(tx_data), 32'h0000_00EE);
        req = '0;
        for (int i = 1; i <= 23; i++) begin
            @(negedge clk_fpga);
            if (i == 5 && clr_during) check("err_cleared", 32'(timeout_err), 32'd0);
            if (i == 16) check("err_before_timeout", 32'(timeout_err), 32'd0);
            if (i == 17) begin
                check("err_at_timeout", 32'(timeout_err), 32'd1);
                err_clr = 1'b0;
            end
            if (i == 22) check("to_gap", {grant, busy}, {4'b0001, 1'b1});
            if (i == 23) check("to_idle_sticky", {grant, busy, timeout_err}, {4'b0000, 1'b0, 1'b1});
        end
    endtask

    initial begin
        int n;
        // Table: round-robin from pointer 3 (reset frame leaves it there).
        tbl[0] = '{4'b0010, 32'h0000_A500, 1, 8'hA5, 1'b0, 40};
        tbl[1] = '{4'b0101, 32'h0033_0011, 2, 8'h33, 1'b0, 6};
        tbl[2] = '{4'b0011, 32'h0000_2211, 0, 8'h11, 1'b0, 8};
        tbl[3] = '{4'b1000, 32'h4400_0000, 3, 8'h44, 1'b0, 5};
        for (int i = 0; i < 8; i++) begin
            tbl[4 + i] = '{4'b1111, 32'hC3C2_C1C0, i % 4, 8'hC0 + 8'(i % 4), (i != 7), 20};
        end

        // Reset values.
        repeat (3) @(negedge clk_fpga);
        check("reset_outputs", {grant, ack, tx_start, tx_data, busy, timeout_err}, 32'd0);
        reset_n = 1'b1;

        // Reset asserted mid-frame (WAIT_DONE) clears outputs asynchronously.
        req      = 4'b0001;
        req_data = 32'h0000_005A;
        wait_start(n);
        check("pre_reset_data", 32'(tx_data), 32'h5A);
        req = '0;
        repeat (2) @(negedge clk_fpga);
        tx_busy = 1'b1;
        repeat (4) @(negedge clk_fpga);
        #2 reset_n = 1'b0;
        #1 check("async_reset", {grant, ack, tx_start, tx_data, busy, timeout_err}, 32'd0);
        @(negedge clk_fpga);
        tx_busy = 1'b0;
        reset_n = 1'b1;
        run_frame('{4'b1000, 32'h7E00_0000, 3, 8'h7E, 1'b0, 5});

        for (int i = 0; i < 12; i++) run_frame(tbl[i]);

        timeout_run(1'b0);
        timeout_run(1'b1);
        err_clr = 1'b1;
        @(negedge clk_fpga);
        err_clr = 1'b0;
        check("err_clr", 32'(timeout_err), 32'd0);

`ifdef UART_TX_LOCK_EN
        begin
            int exp_seq[8];
            exp_seq = '{0, 0, 0, 1, 0, 0, 0, 1};
            run_frame('{4'b1000, 32'h9900_0000, 3, 8'h99, 1'b0, 5});
            req      = 4'b0011;
            req_lock = 4'b0001;
            req_data = 32'h0000_B1B0;
            for (int f = 0; f < 8; f++) begin
                wait_start(n);
                check("lock_grant", 32'(grant), 32'(4'b0001 << exp_seq[f]));
                check("lock_data", 32'(tx_data), (exp_seq[f] == 0) ? 32'hB0 : 32'hB1);
                if (f == 7) begin
                    req      = '0;
                    req_lock = '0;
                end
                repeat (2) @(negedge clk_fpga);
                tx_busy = 1'b1;
                repeat (4) @(negedge clk_fpga);
                tx_busy = 1'b0;
            end
            n = 0;
            do begin
                @(negedge clk_fpga);
                n++;
            end while (busy && n < 40);
            check("lock_idle", 32'(busy), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
